// File: rtl/mem_bus_resizer.sv
// mem_bus_resizer: slave-side adapter between the V810 bus controller and a
// 32-bit synchronous memory model. Emulates a 16/32-bit device with a
// programmable number of wait states, drives ready and bus-size requests, and
// masks data lanes in both directions. Lanes are never shifted.
// Optional 8-bit device emulation is enabled by defining DBR_BYTE_BUS_EN.
module mem_bus_resizer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [31:0] ws,
    input  logic [31:0] dw,
    input  logic        ctlr_da_n,
    input  logic [3:0]  ctlr_be_n,
    output logic        ctlr_ready_n,
    output logic        ctlr_szrq_n,
    output logic [31:0] ctlr_di,
    input  logic [31:0] ctlr_do,
    output logic [31:0] mem_di,
    input  logic [31:0] mem_do
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  ws_sat;
    logic              cycle_act;
    logic              ready;
    logic [BE_W-1:0]   en;
    logic [BE_W-1:0]   lanes;
    logic              split;
    logic [DATA_W-1:0] lane_mask;

    // Saturate the wait-state request to the counter range
    always_comb begin
        ws_sat = ws[CNT_W-1:0];
        if (ws > DATA_W'(CNT_MAX)) begin
            ws_sat = CNT_MAX;
        end
    end

    // Cycle qualifier and ready; >= lets a shrinking WS end a cycle already past it
    always_comb begin
        cycle_act = ~ctlr_da_n & rst_n;
        ready     = cycle_act & (cnt >= ws_sat);
    end

    // Active lane selection and bus-size request condition by device width
    always_comb begin
        en    = ~ctlr_be_n;
        lanes = en;
        split = 1'b0;
        if (dw == 32'd16) begin
            if (|en[1:0]) begin
                lanes = {2'b00, en[1:0]};
            end else begin
                lanes = {en[3:2], 2'b00};
            end
            split = (|en[1:0]) & (|en[3:2]);
        end
`ifdef DBR_BYTE_BUS_EN
        else if (dw == 32'd8) begin
            lanes = en & (~en + BE_W'(1));
            split = |(en & (en - BE_W'(1)));
        end
`endif
    end

    // Expand per-byte lane enables into a data mask
    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            lane_mask[8*i +: 8] = {8{lanes[i]}};
        end
    end

    // Combinational bus-facing outputs; all idle-high/zero outside a cycle
    always_comb begin
        ctlr_ready_n = ~ready;
        ctlr_szrq_n  = ~(cycle_act & split);
        ctlr_di      = cycle_act ? (mem_do & lane_mask) : '0;
        mem_di       = cycle_act ? (ctlr_do & lane_mask) : '0;
    end

    // Wait counter: restarts on idle or on the ready cycle, frozen when ce=0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (ce) begin
            if (ctlr_da_n || ready) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_resizer.sv
// Self-checking bench for mem_bus_resizer: directed scenarios followed by
// randomized traffic compared against a behavioural model of the bus rules.
module tb_mem_bus_resizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [31:0] ws;
    logic [31:0] dw;
    logic        da_n;
    logic [3:0]  be_n;
    logic        ready_n;
    logic        szrq_n;
    logic [31:0] ctlr_di;
    logic [31:0] ctlr_do;
    logic [31:0] mem_di;
    logic [31:0] mem_do;

    int checks = 0;
    int errors = 0;
    int m_waits = 0;   // model: completed wait cycles in the current access

    always #5 clk = ~clk;

    mem_bus_resizer #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .ws           (ws),
        .dw           (dw),
        .ctlr_da_n    (da_n),
        .ctlr_be_n    (be_n),
        .ctlr_ready_n (ready_n),
        .ctlr_szrq_n  (szrq_n),
        .ctlr_di      (ctlr_di),
        .ctlr_do      (ctlr_do),
        .mem_di       (mem_di),
        .mem_do       (mem_do)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ws_eff();
        return (ws > 32'd255) ? 255 : int'(ws);
    endfunction

    function automatic bit m_ready();
        return rst_n && !da_n && (m_waits >= ws_eff());
    endfunction

    function automatic logic [3:0] m_lanes();
        logic [3:0] en;
        logic [3:0] r;
        int half;
        en = ~be_n;
        r  = '0;
        if (dw == 32'd16) begin
            half = (en[0] || en[1]) ? 0 : 1;
            for (int i = 0; i < 4; i++) if (en[i] && (i / 2) == half) r[i] = 1'b1;
        end
`ifdef DBR_BYTE_BUS_EN
        else if (dw == 32'd8) begin
            for (int i = 3; i >= 0; i--) if (en[i]) begin r = '0; r[i] = 1'b1; end
        end
`endif
        else begin
            r = en;
        end
        return r;
    endfunction

    function automatic logic m_szrq_n();
        int lo, hi;
        lo = 0;
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (!be_n[i]) begin
                if (i < 2) lo++; else hi++;
            end
        end
        if (!rst_n || da_n) return 1'b1;
        if (dw == 32'd16) return !(lo > 0 && hi > 0);
`ifdef DBR_BYTE_BUS_EN
        if (dw == 32'd8) return !((lo + hi) > 1);
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_data(input logic [31:0] src);
        logic [31:0] r;
        logic [3:0]  l;
        r = '0;
        l = m_lanes();
        if (rst_n && !da_n) begin
            for (int i = 0; i < 4; i++) if (l[i]) r[8*i +: 8] = src[8*i +: 8];
        end
        return r;
    endfunction

    // Compare all outputs against the model, then advance one clock
    task automatic step(input string tag);
        int nxt;
        #1;
        chk({tag, "/rdy"},  {31'd0, ready_n}, {31'd0, !m_ready()});
        chk({tag, "/szrq"}, {31'd0, szrq_n},  {31'd0, m_szrq_n()});
        chk({tag, "/di"},   ctlr_di, m_data(mem_do));
        chk({tag, "/mdi"},  mem_di,  m_data(ctlr_do));
        nxt = m_waits;
        if (!rst_n) nxt = 0;
        else if (ce) nxt = (da_n || m_ready()) ? 0 : m_waits + 1;
        @(posedge clk);
        m_waits = nxt;
        @(negedge clk);
    endtask

    task automatic idle();
        da_n = 1'b1;
        step("idle");
    endtask

    initial begin
        int dws[4];
        dws = '{16, 32, 8, 7};
        rst_n = 1'b0; ce = 1'b1; ws = 32'd0; dw = 32'd32; da_n = 1'b0; be_n = 4'b0000;
        mem_do = 32'hCAFEF00D; ctlr_do = 32'h0BADBEEF;
        @(negedge clk);
        #1;
        chk("reset/rdy",  {31'd0, ready_n}, 32'd1);
        chk("reset/szrq", {31'd0, szrq_n},  32'd1);
        chk("reset/di",   ctlr_di, 32'd0);
        chk("reset/mdi",  mem_di,  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        da_n  = 1'b1;
        step("post_reset");

        // Zero-wait 32-bit read
        da_n = 1'b0; mem_do = 32'h12345678;
        #1;
        chk("ws0/rdy",  {31'd0, ready_n}, 32'd0);
        chk("ws0/di",   ctlr_di, 32'h12345678);
        chk("ws0/szrq", {31'd0, szrq_n}, 32'd1);
        step("ws0");
        idle();

        // WS=3 back-to-back: ready every 4th cycle
        ws = 32'd3; da_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("ws3/pattern", {31'd0, ready_n}, ((k % 4) == 3) ? 32'd0 : 32'd1);
            step("ws3");
        end
        idle();

        // 16-bit device read, both halves then upper only
        ws = 32'd0; dw = 32'd16; mem_do = 32'hAABBCCDD; da_n = 1'b0; be_n = 4'b0000;
        #1;
        chk("dw16/szrq", {31'd0, szrq_n}, 32'd0);
        chk("dw16/di",   ctlr_di, 32'h0000CCDD);
        step("dw16a");
        be_n = 4'b0011;
        #1;
        chk("dw16hi/szrq", {31'd0, szrq_n}, 32'd1);
        chk("dw16hi/di",   ctlr_di, 32'hAABB0000);
        step("dw16b");

        // 16-bit write, lower half, then idle
        be_n = 4'b1100; ctlr_do = 32'hDEADBEEF;
        #1;
        chk("dw16wr/mdi", mem_di, 32'h0000BEEF);
        step("dw16wr");
        da_n = 1'b1;
        #1;
        chk("idle/mdi", mem_di, 32'd0);
        chk("idle/rdy", {31'd0, ready_n}, 32'd1);
        step("idle16");

        // No lanes enabled: ready still after WS waits, data zero
        be_n = 4'b1111; ws = 32'd1; dw = 32'd32; da_n = 1'b0;
        step("nolane0");
        #1;
        chk("nolane/rdy", {31'd0, ready_n}, 32'd0);
        chk("nolane/di",  ctlr_di, 32'd0);
        step("nolane1");
        idle();

        // WS=5: abort after 2 cycles, then full access
        ws = 32'd5; be_n = 4'b0000; da_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("abort/rdy", {31'd0, ready_n}, 32'd1);
            step("abort");
        end
        idle();
        da_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("ws5/pattern", {31'd0, ready_n}, (k == 5) ? 32'd0 : 32'd1);
            step("ws5");
        end

        // Async reset mid-count clears the counter
        for (int k = 0; k < 3; k++) step("prerst");
        rst_n = 1'b0;
        #1;
        chk("midrst/rdy", {31'd0, ready_n}, 32'd1);
        step("midrst");
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("afterrst/pattern", {31'd0, ready_n}, (k == 5) ? 32'd0 : 32'd1);
            step("afterrst");
        end

        // Shrinking WS mid-cycle ends the access at once
        ws = 32'd5;
        for (int k = 0; k < 3; k++) step("shrink");
        ws = 32'd2;
        #1;
        chk("shrink/rdy", {31'd0, ready_n}, 32'd0);
        step("shrink_done");
        idle();

        // CE gating with WS=2: only ce=1 edges count
        ws = 32'd2; da_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ce = ((k % 2) == 0);
            #1;
            chk("ce/pattern", {31'd0, ready_n}, (k == 3) ? 32'd0 : 32'd1);
            step("ce");
        end
        ce = 1'b1;
        idle();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rst_n   = ($urandom_range(0, 63) != 0);
            ce      = ($urandom_range(0, 3) != 0);
            da_n    = ($urandom_range(0, 3) == 0);
            be_n    = 4'($urandom);
            dw      = 32'(dws[$urandom_range(0, 3)]);
            if ($urandom_range(0, 15) == 0) ws = ($urandom_range(0, 3) == 0) ? 32'd1000 : 32'($urandom_range(0, 4));
            mem_do  = $urandom;
            ctlr_do = $urandom;
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
